// File: rtl/modexp_seq_ctrl.sv
// ---------------------------------------------------------------------------------------------
// modexp_seq_ctrl
//
// Sequential scheduler for (a ^ e) mod n. One external Montgomery multiplier is shared
// through a req/ack handshake. The exponent is scanned right to left (square-and-multiply) in
// the Montgomery domain. Operands are loaded into the domain with mont(a, R^2) and
// mont(R^2, 1). The result is brought back out with mont(acc, 1).
//
// Optional feature (macro MODEXP_SEQ_PERF_EN):
//   perf_ops    [7:0]   ops retired by mm_ack in the current/last run
//   perf_cycles [31:0]  cycles with busy=1, saturating
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   start                start request, sampled only while idle
//   a, e, n              base, exponent, odd modulus
//   n_prime, r2_mod_n    -n^-1 mod R and R^2 mod n
//   busy, done, res      status, one-cycle completion pulse, result
//   mm_req, mm_a, mm_b   multiplier request and operands (stable while mm_req)
//   mm_n, mm_n_prime     registered modulus constants for the multiplier
//   mm_ack, mm_res       multiplier completion pulse and product
// ---------------------------------------------------------------------------------------------
module modexp_seq_ctrl #(
    parameter int unsigned LEN   = 2048,
    parameter int unsigned EBITS = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN-1:0]   a,
    input  logic [EBITS-1:0] e,
    input  logic [LEN-1:0]   n,
    input  logic [LEN-1:0]   n_prime,
    input  logic [LEN-1:0]   r2_mod_n,
    output logic             busy,
    output logic             done,
    output logic [LEN-1:0]   res,
    output logic             mm_req,
    output logic [LEN-1:0]   mm_a,
    output logic [LEN-1:0]   mm_b,
    output logic [LEN-1:0]   mm_n,
    output logic [LEN-1:0]   mm_n_prime,
    input  logic             mm_ack,
    input  logic [LEN-1:0]   mm_res
`ifdef MODEXP_SEQ_PERF_EN
    ,
    output logic [7:0]       perf_ops,
    output logic [31:0]      perf_cycles
`endif
);

    localparam int unsigned   IW       = (EBITS > 1) ? $clog2(EBITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(EBITS - 1);
    localparam logic [LEN-1:0] ONE     = LEN'(1);

    typedef enum logic [2:0] {
        StIdle,
        StLdBase,
        StLdAcc,
        StMul,
        StSqr,
        StFinal
    } state_e;

    state_e           state_q, state_d;
    logic             req_q, req_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [LEN-1:0]   res_q, res_d;
    logic [LEN-1:0]   a_q, a_d;
    logic [LEN-1:0]   n_q, n_d;
    logic [LEN-1:0]   np_q, np_d;
    logic [LEN-1:0]   r2_q, r2_d;
    logic [EBITS-1:0] ebuf_q, ebuf_d;
    logic [LEN-1:0]   base_q, base_d;
    logic [LEN-1:0]   acc_q, acc_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [LEN-1:0]   op_a, op_b;
    logic             ack_ok;
    logic             start_acc;

    // Zero-cycle BIT decision: which op follows for exponent bit i.
    function automatic state_e bit_decide(input logic [EBITS-1:0] eb, input logic [IW-1:0] i);
        if (eb[i]) begin
            return StMul;
        end else if (i < LAST_IDX) begin
            return StSqr;
        end else begin
            return StFinal;
        end
    endfunction

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        res_d     = res_q;
        a_d       = a_q;
        n_d       = n_q;
        np_d      = np_q;
        r2_d      = r2_q;
        ebuf_d    = ebuf_q;
        base_d    = base_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        op_a      = '0;
        op_b      = '0;
        // An ack only counts against an outstanding request.
        ack_ok    = req_q & mm_ack;
        // A start in the done cycle is dropped; it is accepted from the following cycle.
        start_acc = (state_q == StIdle) && start && !done_q;

        unique case (state_q)
            StIdle: begin
                if (start_acc) begin
                    a_d     = a;
                    n_d     = n;
                    np_d    = n_prime;
                    r2_d    = r2_mod_n;
                    ebuf_d  = e;
                    busy_d  = 1'b1;
                    state_d = StLdBase;
                end
            end
            StLdBase: begin
                op_a = a_q;
                op_b = r2_q;
                if (ack_ok) begin
                    base_d  = mm_res;
                    state_d = StLdAcc;
                end
            end
            StLdAcc: begin
                op_a = r2_q;
                op_b = ONE;
                if (ack_ok) begin
                    acc_d   = mm_res;
                    idx_d   = '0;
                    state_d = bit_decide(ebuf_q, '0);
                end
            end
            StMul: begin
                op_a = acc_q;
                op_b = base_q;
                if (ack_ok) begin
                    acc_d   = mm_res;
                    state_d = (idx_q < LAST_IDX) ? StSqr : StFinal;
                end
            end
            StSqr: begin
                op_a = base_q;
                op_b = base_q;
                if (ack_ok) begin
                    base_d  = mm_res;
                    idx_d   = idx_q + IW'(1);
                    state_d = bit_decide(ebuf_q, idx_q + IW'(1));
                end
            end
            StFinal: begin
                op_a = acc_q;
                op_b = ONE;
                if (ack_ok) begin
                    res_d   = mm_res;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Every op state raises req one cycle after entry and drops it after the ack edge,
        // which guarantees at least one idle cycle between consecutive requests.
        if (state_q != StIdle) begin
            if (!req_q) begin
                req_d = 1'b1;
            end else if (mm_ack) begin
                req_d = 1'b0;
            end
        end else begin
            req_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
            a_q     <= '0;
            n_q     <= '0;
            np_q    <= '0;
            r2_q    <= '0;
            ebuf_q  <= '0;
            base_q  <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            res_q   <= res_d;
            a_q     <= a_d;
            n_q     <= n_d;
            np_q    <= np_d;
            r2_q    <= r2_d;
            ebuf_q  <= ebuf_d;
            base_q  <= base_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign res        = res_q;
    assign mm_req     = req_q;
    assign mm_a       = op_a;
    assign mm_b       = op_b;
    assign mm_n       = n_q;
    assign mm_n_prime = np_q;

`ifdef MODEXP_SEQ_PERF_EN
    logic [7:0]  perf_ops_q;
    logic [31:0] perf_cycles_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_ops_q    <= '0;
            perf_cycles_q <= '0;
        end else if (start_acc) begin
            perf_ops_q    <= '0;
            perf_cycles_q <= '0;
        end else begin
            if (ack_ok && (state_q != StIdle) && (perf_ops_q != 8'hFF)) begin
                perf_ops_q <= perf_ops_q + 8'd1;
            end
            if (busy_q && (perf_cycles_q != 32'hFFFF_FFFF)) begin
                perf_cycles_q <= perf_cycles_q + 32'd1;
            end
        end
    end

    assign perf_ops    = perf_ops_q;
    assign perf_cycles = perf_cycles_q;
`endif

endmodule
